// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// operand forward-select codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    DRAIN = 2'b00,
    RUN   = 2'b01,
    DMISS = 2'b10
  } hz_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forward select for one E-stage source register; M result wins over W,
// and x0 is never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              en,
  input  logic              rs_used,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output logic [1:0]        fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (en && rs_used) begin
      if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
        fwd = FWD_M;
      end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
        fwd = FWD_W;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: stall/flush sequencing, forwarding and
// D-cache miss supervision. Optional perf counters under HAZARD_PERF_CNT_EN.
//   state | meaning
//   DRAIN | post-reset flush, every stage cleared until drain counter empties
//   RUN   | normal operation, per-cycle hazard resolution
//   DMISS | D-cache miss pending, F..M frozen, W bubbled
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW           = 5,
  parameter int RST_FLUSH_CYCLES = 2,
  parameter int MISS_TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              CpuRst,
  input  logic              ICacheMiss,
  input  logic              DCacheMiss,
  input  logic              BranchE,
  input  logic              JalrE,
  input  logic              JalD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic [1:0]        RegReadE,
  input  logic              MemToRegE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              StallW,
  output logic              FlushF,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        Forward1E,
  output logic [1:0]        Forward2E,
  output logic [1:0]        HazState,
  output logic              MissTimeout,
  output logic [31:0]       StallCycles,
  output logic [31:0]       FlushEvents
);

  localparam logic [3:0]  DRAIN_LOAD = 4'(RST_FLUSH_CYCLES);
  localparam logic [15:0] MISS_TO    = 16'(MISS_TIMEOUT);

  hz_state_t   state, state_nxt;
  logic [3:0]  drain_cnt, drain_nxt;
  logic [15:0] miss_cnt, miss_inc;
  logic        lu_done, lu_act;
  logic        fwd_en;
  logic        load_use, redirect;

  assign load_use = MemToRegE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign redirect = BranchE || JalrE;
  assign miss_inc = (miss_cnt == MISS_TO) ? miss_cnt : miss_cnt + 16'd1;
  assign HazState = state;

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    lu_act    = 1'b0;
    fwd_en    = 1'b1;
    {StallF, StallD, StallE, StallM, StallW} = 5'b00000;
    {FlushF, FlushD, FlushE, FlushM, FlushW} = 5'b00000;
    if (CpuRst) begin
      {FlushF, FlushD, FlushE, FlushM, FlushW} = 5'b11111;
      fwd_en = 1'b0;
    end else begin
      case (state)
        DRAIN: begin
          {FlushF, FlushD, FlushE, FlushM, FlushW} = 5'b11111;
          fwd_en    = 1'b0;
          drain_nxt = (drain_cnt == '0) ? '0 : drain_cnt - 4'd1;
          if (drain_nxt == '0) state_nxt = RUN;
        end
        RUN: begin
          if (DCacheMiss) begin
            {StallF, StallD, StallE, StallM} = 4'b1111;
            FlushW    = 1'b1;
            state_nxt = DMISS;
          end else if (redirect) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (load_use && !lu_done) begin
            // lu_done blocks a second bubble if the load is still seen in E
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
            lu_act = 1'b1;
          end else begin
            StallF = ICacheMiss;
            FlushD = ICacheMiss | JalD;
          end
        end
        DMISS: begin
          {StallF, StallD, StallE, StallM} = 4'b1111;
          FlushW = 1'b1;
          if (!DCacheMiss) state_nxt = RUN;
        end
        default: begin
          {FlushF, FlushD, FlushE, FlushM, FlushW} = 5'b11111;
          fwd_en    = 1'b0;
          state_nxt = DRAIN;
          drain_nxt = DRAIN_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (CpuRst) begin
      state       <= DRAIN;
      drain_cnt   <= DRAIN_LOAD;
      miss_cnt    <= '0;
      MissTimeout <= 1'b0;
      lu_done     <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      lu_done   <= lu_act;
      if (state == DMISS) begin
        miss_cnt <= (state_nxt == RUN) ? '0 : miss_inc;
        if (miss_inc == MISS_TO) MissTimeout <= 1'b1;
      end
    end
  end

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd1 (
    .en          (fwd_en),
    .rs_used     (RegReadE[1]),
    .rs          (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (Forward1E)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd2 (
    .en          (fwd_en),
    .rs_used     (RegReadE[0]),
    .rs          (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (Forward2E)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cyc, flush_evt;
  logic        any_stall;

  assign any_stall = StallF | StallD | StallE | StallM | StallW;

  always_ff @(posedge clk) begin
    if (CpuRst) begin
      stall_cyc <= '0;
      flush_evt <= '0;
    end else begin
      if ((state == RUN || state == DMISS) && any_stall && (stall_cyc != '1))
        stall_cyc <= stall_cyc + 32'd1;
      if ((FlushD || FlushE) && (flush_evt != '1))
        flush_evt <= flush_evt + 32'd1;
    end
  end

  assign StallCycles = stall_cyc;
  assign FlushEvents = flush_evt;
`else
  assign StallCycles = '0;
  assign FlushEvents = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, multi-cycle
// sequences and randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int RST_FC  = 2;
  localparam int MISS_TO = 4;

  localparam logic [16:0] M_ALL = 17'h1FFFF;
  localparam logic [16:0] M_ST  = 17'h1F000;
  localparam logic [16:0] M_SF  = 17'h1FF80;
  localparam logic [16:0] M_SFF = 17'h1FFF8;
  localparam logic [16:0] M_HS  = 17'h00006;
  localparam logic [16:0] M_TO  = 17'h00001;

  typedef struct packed {
    bit       rst, imiss, dmiss, br, jalr, jald, mtr, rwm, rww;
    bit [1:0] rr;
    bit [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  } vec_in_t;

  typedef struct {
    string       name;
    vec_in_t     vin;
    logic [16:0] exp;
  } tvec_t;

  logic        clk;
  logic        CpuRst, ICacheMiss, DCacheMiss, BranchE, JalrE, JalD;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  RegReadE;
  logic        MemToRegE, RegWriteM, RegWriteW;
  logic        StallF, StallD, StallE, StallM, StallW;
  logic        FlushF, FlushD, FlushE, FlushM, FlushW;
  logic [1:0]  Forward1E, Forward2E, HazState;
  logic        MissTimeout;
  logic [31:0] StallCycles, FlushEvents;

  int n_checks = 0;
  int n_err    = 0;

  // model state: mode uses the observable HazState codes 0 drain, 1 run, 2 dmiss
  int          m_mode, m_drain_left, m_miss_n;
  bit          m_to, m_bubble;
  logic [16:0] last;
  tvec_t       tbl[$];

  pipe_hazard_ctrl #(.REG_AW(5), .RST_FLUSH_CYCLES(RST_FC), .MISS_TIMEOUT(MISS_TO)) dut (
    .clk(clk), .CpuRst(CpuRst), .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
    .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegReadE(RegReadE), .MemToRegE(MemToRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushF(FlushF), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .Forward1E(Forward1E), .Forward2E(Forward2E), .HazState(HazState),
    .MissTimeout(MissTimeout), .StallCycles(StallCycles), .FlushEvents(FlushEvents)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [16:0] O(input bit [4:0] st, input bit [4:0] fl, input bit [1:0] f1,
                                    input bit [1:0] f2, input bit [1:0] hs, input bit to);
    return {st, fl, f1, f2, hs, to};
  endfunction

  function automatic logic [16:0] E(input bit [4:0] st, input bit [4:0] fl,
                                    input bit [1:0] f1, input bit [1:0] f2);
    return O(st, fl, f1, f2, 2'b01, 1'b0);
  endfunction

  function automatic logic [16:0] sample();
    return {StallF, StallD, StallE, StallM, StallW, FlushF, FlushD, FlushE, FlushM, FlushW,
            Forward1E, Forward2E, HazState, MissTimeout};
  endfunction

  function automatic bit is_lu(input vec_in_t v);
    return v.mtr && (v.rde != 0) && (v.rde == v.rs1d || v.rde == v.rs2d);
  endfunction

  function automatic bit [1:0] ref_fwd(input bit used, input bit [4:0] rs, input vec_in_t v);
    if (!used) return 2'b00;
    if (v.rwm && v.rdm != 0 && v.rdm == rs) return 2'b10;
    if (v.rww && v.rdw != 0 && v.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [16:0] model_out(input vec_in_t v);
    bit [4:0] st = '0;
    bit [4:0] fl = '0;
    bit [1:0] f1 = '0;
    bit [1:0] f2 = '0;
    if (v.rst || m_mode == 0) fl = 5'b11111;
    else if (m_mode == 2 || v.dmiss) begin st = 5'b11110; fl = 5'b00001; end
    else if (v.br || v.jalr) fl = 5'b01100;
    else if (is_lu(v) && !m_bubble) begin st = 5'b11000; fl = 5'b00100; end
    else begin st = {v.imiss, 4'b0000}; fl = {1'b0, v.imiss | v.jald, 3'b000}; end
    if (!v.rst && m_mode != 0) begin
      f1 = ref_fwd(v.rr[1], v.rs1e, v);
      f2 = ref_fwd(v.rr[0], v.rs2e, v);
    end
    return O(st, fl, f1, f2, 2'(m_mode), m_to);
  endfunction

  task automatic model_update(input vec_in_t v);
    if (v.rst) begin
      m_mode = 0;
      m_drain_left = (RST_FC == 0) ? 1 : RST_FC;
      m_miss_n = 0;
      m_to = 1'b0;
      m_bubble = 1'b0;
    end else if (m_mode == 0) begin
      m_drain_left--;
      if (m_drain_left == 0) m_mode = 1;
    end else if (m_mode == 1) begin
      m_bubble = !v.dmiss && !(v.br || v.jalr) && is_lu(v) && !m_bubble;
      if (v.dmiss) begin m_mode = 2; m_miss_n = 0; end
    end else begin
      m_miss_n++;
      if (m_miss_n >= MISS_TO) m_to = 1'b1;
      m_bubble = 1'b0;
      if (!v.dmiss) m_mode = 1;
    end
  endtask

  task automatic chk(input string name, input logic [16:0] got, input logic [16:0] exp,
                     input logic [16:0] mask);
    n_checks++;
    if ((got & mask) !== (exp & mask)) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (mask %h)", name, got & mask, exp & mask, mask);
    end
  endtask

  task automatic drive(input vec_in_t v);
    CpuRst = v.rst; ICacheMiss = v.imiss; DCacheMiss = v.dmiss; BranchE = v.br;
    JalrE = v.jalr; JalD = v.jald; MemToRegE = v.mtr; RegWriteM = v.rwm; RegWriteW = v.rww;
    RegReadE = v.rr; Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
    RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
  endtask

  task automatic step(input vec_in_t v, input string name);
    @(negedge clk);
    drive(v);
    #1;
    last = sample();
    chk(name, last, model_out(v), M_ALL);
    model_update(v);
  endtask

  task automatic tstep(input tvec_t t);
    @(negedge clk);
    drive(t.vin);
    #1;
    last = sample();
    chk(t.name, last, t.exp, M_ALL);
    model_update(t.vin);
  endtask

  task automatic add(input string n, input vec_in_t v, input logic [16:0] e);
    tvec_t t;
    t.name = n; t.vin = v; t.exp = e;
    tbl.push_back(t);
  endtask

  task automatic do_reset();
    vec_in_t r;
    r = '0; r.rst = 1'b1;
    step(r, "reset");
    r = '0;
    step(r, "drain_a");
    step(r, "drain_b");
  endtask

  initial begin
    vec_in_t v;
    int miss_left;

    v = '0;                                                    add("idle",        v, E(0, 0, 0, 0));
    v.rdm = 5; v.rdw = 5; v.rwm = 1; v.rww = 1; v.rs1e = 5; v.rr = 2'b10;
                                                               add("fwd_m",       v, E(0, 0, 2'b10, 0));
    v.rdm = 0;                                                 add("fwd_w",       v, E(0, 0, 2'b01, 0));
    v = '0; v.rr = 2'b01; v.rs2e = 7; v.rdm = 7; v.rdw = 7; v.rwm = 1; v.rww = 1;
                                                               add("fwd_m_op2",   v, E(0, 0, 0, 2'b10));
    v.rwm = 0;                                                 add("fwd_w_op2",   v, E(0, 0, 0, 2'b01));
    v = '0; v.rr = 2'b11; v.rwm = 1; v.rww = 1;                add("fwd_x0",      v, E(0, 0, 0, 0));
    v = '0; v.rs1e = 6; v.rdm = 6; v.rwm = 1;                  add("fwd_unused",  v, E(0, 0, 0, 0));
    v = '0; v.rr = 2'b11; v.rs1e = 2; v.rs2e = 9; v.rdm = 2; v.rdw = 9; v.rwm = 1; v.rww = 1;
                                                               add("fwd_both",    v, E(0, 0, 2'b10, 2'b01));
    v = '0; v.br = 1;                                          add("branch",      v, E(0, 5'b01100, 0, 0));
    v = '0; v.jalr = 1;                                        add("jalr",        v, E(0, 5'b01100, 0, 0));
    v = '0; v.jald = 1;                                        add("jald",        v, E(0, 5'b01000, 0, 0));
    v = '0; v.imiss = 1;                                       add("imiss",       v, E(5'b10000, 5'b01000, 0, 0));
    v = '0; v.mtr = 1; v.rde = 3; v.rs2d = 3;                  add("lu_rs2",      v, E(5'b11000, 5'b00100, 0, 0));
    v = '0;                                                    add("lu_release",  v, E(0, 0, 0, 0));
    v = '0; v.mtr = 1; v.rde = 3; v.rs1d = 3; v.imiss = 1;     add("lu_imiss",    v, E(5'b11000, 5'b00100, 0, 0));
    v = '0;                                                    add("idle2",       v, E(0, 0, 0, 0));
    v = '0; v.mtr = 1; v.rde = 3; v.rs2d = 3; v.br = 1; v.imiss = 1;
                                                               add("lu_br_imiss", v, E(0, 5'b01100, 0, 0));
    v = '0; v.mtr = 1;                                         add("lu_rd0",      v, E(0, 0, 0, 0));
    v = '0; v.jald = 1; v.br = 1;                              add("jald_br",     v, E(0, 5'b01100, 0, 0));
    v = '0; v.imiss = 1; v.jald = 1;                           add("imiss_jald",  v, E(5'b10000, 5'b01000, 0, 0));

    // first reset cycle: state register unknown, only the combinational reset outputs are checked
    v = '0; v.rst = 1; v.rdm = 5; v.rwm = 1; v.rs1e = 5; v.rr = 2'b10;
    @(negedge clk);
    drive(v);
    #1;
    last = sample();
    chk("reset_comb", last, O(0, 5'b11111, 0, 0, 0, 0), M_SFF);
    model_update(v);

    v = '0;
    step(v, "drain_0"); chk("drain_hs_0", last, O(0, 0, 0, 0, 2'b00, 0), M_HS);
    step(v, "drain_1"); chk("drain_hs_1", last, O(0, 0, 0, 0, 2'b00, 0), M_HS);
    step(v, "run_0");   chk("run_entry",  last, O(0, 0, 0, 0, 2'b01, 0), M_HS);

    foreach (tbl[i]) tstep(tbl[i]);

    // load held in E across two cycles: only one bubble
    v = '0; v.mtr = 1; v.rde = 3; v.rs2d = 3;
    step(v, "lu_hold_0"); chk("lu_first",     last, O(5'b11000, 5'b00100, 0, 0, 0, 0), M_SF);
    step(v, "lu_hold_1"); chk("lu_no_second", last, O(0, 0, 0, 0, 0, 0), M_SF);
    v = '0; step(v, "lu_after");

    // D-miss for 10 cycles with a taken branch held in E
    v = '0; v.br = 1; v.dmiss = 1;
    for (int k = 0; k < 10; k++) begin
      step(v, "dmiss_hold");
      chk("dmiss_stall", last, O(5'b11110, 5'b00001, 0, 0, 0, 0), M_SF);
    end
    v.dmiss = 0;
    step(v, "dmiss_fall"); chk("dmiss_fall_state", last, O(0, 0, 0, 0, 2'b10, 0), M_HS);
    step(v, "dmiss_exit");
    chk("branch_after_miss", last, O(0, 5'b01100, 0, 0, 2'b01, 1), M_SF | M_HS | M_TO);
    v = '0; step(v, "post_miss");

    // reset with forwarding inputs live, then drain length and timeout clear
    v = '0; v.rst = 1; v.rdm = 5; v.rdw = 5; v.rwm = 1; v.rww = 1; v.rs1e = 5; v.rr = 2'b10;
    step(v, "reset_fwd"); chk("reset_outputs", last, O(0, 5'b11111, 0, 0, 0, 0), M_SFF);
    v = '0;
    step(v, "rst_drain_0"); chk("rst_clear", last, O(0, 0, 0, 0, 2'b00, 0), M_HS | M_TO);
    step(v, "rst_drain_1"); chk("rst_drain_hs", last, O(0, 0, 0, 0, 2'b00, 0), M_HS);
    step(v, "rst_run");     chk("rst_run_hs",   last, O(0, 0, 0, 0, 2'b01, 0), M_HS);

    // timeout boundary: 3 DMISS cycles stays clear, 4 sets the flag
    v = '0; v.dmiss = 1;
    for (int k = 0; k < 3; k++) step(v, "miss3");
    v.dmiss = 0; step(v, "miss3_fall"); step(v, "miss3_run");
    chk("timeout_below", last, O(0, 0, 0, 0, 2'b01, 0), M_HS | M_TO);
    v.dmiss = 1;
    for (int k = 0; k < 4; k++) step(v, "miss4");
    v.dmiss = 0; step(v, "miss4_fall"); step(v, "miss4_run");
    chk("timeout_at", last, O(0, 0, 0, 0, 2'b01, 1), M_HS | M_TO);
    do_reset();

    // reset during DMISS aborts the miss
    v = '0; v.dmiss = 1;
    step(v, "abort_0"); step(v, "abort_1");
    v.rst = 1; step(v, "abort_rst");
    v.rst = 0; step(v, "abort_after");
    chk("rst_abort_dmiss", last, O(0, 0, 0, 0, 2'b00, 0), M_ST | M_HS);
    v = '0; step(v, "abort_drain");

    miss_left = 0;
    for (int i = 0; i < 600; i++) begin
      v = '0;
      v.rst   = ($urandom_range(0, 63) == 0);
      v.imiss = ($urandom % 4 == 0);
      if (miss_left > 0) begin
        v.dmiss = 1'b1;
        miss_left--;
      end else if ($urandom % 16 == 0) begin
        miss_left = $urandom_range(1, 7);
      end
      v.br   = ($urandom % 6 == 0);
      v.jalr = ($urandom % 10 == 0);
      v.jald = ($urandom % 6 == 0);
      v.mtr  = ($urandom % 3 == 0);
      v.rwm  = $urandom_range(0, 1) == 1;
      v.rww  = $urandom_range(0, 1) == 1;
      v.rr   = 2'($urandom_range(0, 3));
      v.rs1d = 5'($urandom_range(0, 3));
      v.rs2d = 5'($urandom_range(0, 3));
      v.rs1e = 5'($urandom_range(0, 3));
      v.rs2e = 5'($urandom_range(0, 3));
      v.rde  = 5'($urandom_range(0, 3));
      v.rdm  = 5'($urandom_range(0, 3));
      v.rdw  = 5'($urandom_range(0, 3));
      step(v, "random");
    end

    $display("perf counters (tied off unless enabled): %0d %0d", StallCycles, FlushEvents);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5: register-address width.
REQ-002 Parameter RST_FLUSH_CYCLES, default 2: post-reset flush cycles, legal range 0..15.
REQ-003 Parameter MISS_TIMEOUT, default 255: D-miss wait cycles before timeout flag, legal range 1..65535.
REQ-004 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 Port CpuRst, input, 1: reset, synchronous and active-high.
REQ-006 Ports ICacheMiss and DCacheMiss, input, 1 each: cache miss pending, level-held until serviced.
REQ-007 Ports BranchE and JalrE, input, 1 each: taken redirect resolved in E. Port JalD, input, 1: jal decoded in D.
REQ-008 Ports Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM and RdW, input, REG_AW each: source and destination register numbers.
REQ-009 Port RegReadE, input, 2: bit1 means Rs1E is used, bit0 means Rs2E is used. Port MemToRegE, input, 1: the E instruction is a load.
REQ-010 Ports RegWriteM and RegWriteW, input, 1 each: the M or W instruction writes Rd.
REQ-011 Ports StallF/D/E/M/W and FlushF/D/E/M/W, output, 1 each: per-stage register hold and clear.
REQ-012 Ports Forward1E and Forward2E, output, 2 each: operand source select, 00 = regfile, 10 = M, 01 = W.
REQ-013 Port HazState, output, 2: FSM state, 00 = DRAIN, 01 = RUN, 10 = DMISS.
REQ-014 Port MissTimeout, output, 1: sticky D-miss timeout flag.

Function
REQ-015 ForwardxE SHALL be 10 when RegReadE bit set, RegWriteM=1, RdM!=0 and RdM==RsxE; else 01 under the same rule for W; else 00. M has priority over W. The path is combinational, 0 cycles.
REQ-016 Load-use is MemToRegE=1 with RdE!=0 and RdE equal to Rs1D or Rs2D. In RUN it SHALL assert StallF, StallD and FlushE for exactly one cycle; no second bubble.
REQ-017 BranchE or JalrE in RUN SHALL assert FlushD and FlushE, deassert StallF, and override load-use and ICacheMiss.
REQ-018 JalD without BranchE or JalrE SHALL assert FlushD.
REQ-019 ICacheMiss in RUN, with no E redirect, SHALL assert StallF and FlushD. Combined with load-use, the result is StallF, StallD and FlushE.
REQ-020 FSM DRAIN: all Flush=1, all Stall=0, Forward=00. It decrements a 4-bit counter each cycle and moves to RUN when the counter is 0.
REQ-021 FSM RUN: on DCacheMiss=1 the same cycle SHALL assert StallF/D/E/M and FlushW, and the FSM SHALL go to DMISS.
REQ-022 FSM DMISS: assert StallF/D/E/M and FlushW. Redirect, JalD and load-use are ignored.
REQ-023 DMISS exits to RUN in the cycle after DCacheMiss is seen at 0. The held BranchE is then acted on in RUN.
REQ-024 A 16-bit miss counter SHALL count DMISS cycles. Reaching MISS_TIMEOUT SHALL set MissTimeout, which is cleared only by CpuRst; the counter saturates and clears on entering RUN.
REQ-025 When no hazard applies, all Stall and Flush outputs SHALL be 0.

Reset
REQ-026 While CpuRst=1, all Flush outputs SHALL be 1 combinationally, all Stall outputs 0, and Forward 00.
REQ-027 On a CpuRst=1 edge: state to DRAIN, drain counter loaded with RST_FLUSH_CYCLES, miss counter and MissTimeout cleared, perf counters cleared.
REQ-028 CpuRst asserted in any state, including mid-DMISS, SHALL abort that state on the next edge.

Configuration
REQ-029 With HAZARD_PERF_CNT_EN defined, 32-bit outputs StallCycles and FlushEvents SHALL count RUN/DMISS cycles with any Stall=1 and cycles with FlushD or FlushE=1, saturating at all-ones.
REQ-030 Without HAZARD_PERF_CNT_EN, both ports SHALL remain present and tied to 0, and the counter logic SHALL be absent.

Structure
REQ-031 Package hazard_pkg SHALL hold the state enum (DRAIN, RUN, DMISS) and the forward codes FWD_RF, FWD_M, FWD_W.
REQ-032 Forward selection SHALL be sub-module hazard_fwd_sel, instantiated once per E source operand.

Verification
REQ-033 Forwarding: RdM=RdW=5, RegWriteM=RegWriteW=1, Rs1E=5, RegReadE=10 -> Forward1E=10, Forward2E=00. Same stimulus with RdM=0 -> Forward1E=01.
REQ-034 Load-use: MemToRegE=1, RdE=3, Rs2D=3, then the next cycle with MemToRegE=0 -> StallF/StallD/FlushE=1 for exactly one cycle.
REQ-035 Simultaneous events: load-use + BranchE + ICacheMiss in one cycle -> FlushD=FlushE=1, StallF=0, StallD=0.
REQ-036 DMISS: DCacheMiss high for 10 cycles with BranchE held -> StallF/D/E/M high for 10 cycles; FSM leaves DMISS the cycle after DCacheMiss falls; BranchE flush appears on the first RUN cycle.
REQ-037 Reset: MISS_TIMEOUT=4 with DCacheMiss held 6 cycles -> MissTimeout=1. Then CpuRst=1 for 1 cycle -> MissTimeout=0, HazState=00 for RST_FLUSH_CYCLES=2 cycles, then 01.
